// File: rtl/register_file_sb_pkg.sv
// Shared CPU constants: default register-file geometry and fixed register indices.
package cpu_pkg;

    localparam int WORD_SIZE_D = 16;
    localparam int REG_NUM_D   = 8;
    localparam int ADDR_W_D    = $clog2(REG_NUM_D);
    localparam int REG_ZERO    = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservations from decode, releases from writeback.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int REG_NUM  = REG_NUM_D,
    parameter int ADDR_W   = $clog2(REG_NUM),
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] addr_rsv,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic              busy1,
    output logic              busy2
);

    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_nxt;
    logic               rsv_zero;

    assign rsv_zero = (ZERO_REG != 0) && (addr_rsv == ADDR_W'(REG_ZERO));

    // Set is applied after clear so a new producer wins over a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (write) begin
            busy_nxt[addr_in] = 1'b0;
        end
        if (reserve && !rsv_zero) begin
            busy_nxt[addr_rsv] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy1 = busy[addr1] && !(write && (addr_in == addr1));
    assign busy2 = busy[addr2] && !(write && (addr_in == addr2));

endmodule

// File: rtl/register_file_sb.sv
// Register file with one write port, two buffered read ports, write bypass
// and a busy scoreboard for stalling on pending results.
module register_file_sb
    import cpu_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_D,
    parameter int REG_NUM   = REG_NUM_D,
    parameter int ADDR_W    = $clog2(REG_NUM),
    parameter int ZERO_REG  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [ADDR_W-1:0]    addr2,
    input  logic                 write_buff1,
    input  logic                 write_buff2,
    output logic [WORD_SIZE-1:0] reg_buff1,
    output logic [WORD_SIZE-1:0] reg_buff2,
    input  logic                 reserve,
    input  logic [ADDR_W-1:0]    addr_rsv,
    output logic                 busy1,
    output logic                 busy2
);

    logic [WORD_SIZE-1:0] reg_file [REG_NUM];
    logic [WORD_SIZE-1:0] rd1;
    logic [WORD_SIZE-1:0] rd2;
    logic                 wr_zero;
    logic                 rd1_zero;
    logic                 rd2_zero;

    assign wr_zero  = (ZERO_REG != 0) && (addr_in == ADDR_W'(REG_ZERO));
    assign rd1_zero = (ZERO_REG != 0) && (addr1 == ADDR_W'(REG_ZERO));
    assign rd2_zero = (ZERO_REG != 0) && (addr2 == ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                reg_file[i] <= '0;
            end
        end else if (write && !wr_zero) begin
            reg_file[addr_in] <= data_in;
        end
    end

    always_comb begin
        rd1 = reg_file[addr1];
        if (rd1_zero) begin
            rd1 = '0;
        end else if (write && (addr_in == addr1)) begin
            rd1 = data_in;
        end
    end

    always_comb begin
        rd2 = reg_file[addr2];
        if (rd2_zero) begin
            rd2 = '0;
        end else if (write && (addr_in == addr2)) begin
            rd2 = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_buff1 <= '0;
            reg_buff2 <= '0;
        end else begin
            if (write_buff1) begin
                reg_buff1 <= rd1;
            end
            if (write_buff2) begin
                reg_buff2 <= rd2;
            end
        end
    end

    regfile_scoreboard #(
        .REG_NUM  (REG_NUM),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .addr_in  (addr_in),
        .reserve  (reserve),
        .addr_rsv (addr_rsv),
        .addr1    (addr1),
        .addr2    (addr2),
        .busy1    (busy1),
        .busy2    (busy2)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench: vector table on the default instance, hand sequences for
// the zero-register and wide/deep parametrisations.
module tb_register_file_sb;

    logic clk;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst, wr, b1, b2, rs;
    logic [2:0]  ai, a1, a2, ar;
    logic [15:0] di, q1, q2;
    logic        u1, u2;

    register_file_sb dut (
        .clk(clk), .rst(rst), .write(wr), .addr_in(ai), .data_in(di),
        .addr1(a1), .addr2(a2), .write_buff1(b1), .write_buff2(b2),
        .reg_buff1(q1), .reg_buff2(q2), .reserve(rs), .addr_rsv(ar),
        .busy1(u1), .busy2(u2)
    );

    // zero-register instance
    logic        z_rst, z_wr, z_b1, z_b2, z_rs;
    logic [2:0]  z_ai, z_a1, z_a2, z_ar;
    logic [15:0] z_di, z_q1, z_q2;
    logic        z_u1, z_u2;

    register_file_sb #(.ZERO_REG(1)) dz (
        .clk(clk), .rst(z_rst), .write(z_wr), .addr_in(z_ai), .data_in(z_di),
        .addr1(z_a1), .addr2(z_a2), .write_buff1(z_b1), .write_buff2(z_b2),
        .reg_buff1(z_q1), .reg_buff2(z_q2), .reserve(z_rs), .addr_rsv(z_ar),
        .busy1(z_u1), .busy2(z_u2)
    );

    // wide/deep instance
    logic        w_rst, w_wr, w_b1, w_b2, w_rs;
    logic [3:0]  w_ai, w_a1, w_a2, w_ar;
    logic [31:0] w_di, w_q1, w_q2;
    logic        w_u1, w_u2;

    register_file_sb #(.WORD_SIZE(32), .REG_NUM(16), .ADDR_W(4)) dw (
        .clk(clk), .rst(w_rst), .write(w_wr), .addr_in(w_ai), .data_in(w_di),
        .addr1(w_a1), .addr2(w_a2), .write_buff1(w_b1), .write_buff2(w_b2),
        .reg_buff1(w_q1), .reg_buff2(w_q2), .reserve(w_rs), .addr_rsv(w_ar),
        .busy1(w_u1), .busy2(w_u2)
    );

    typedef struct {
        logic        rst, wr;
        logic [2:0]  ai;
        logic [15:0] di;
        logic [2:0]  a1, a2;
        logic        b1, b2, rs;
        logic [2:0]  ar;
        logic [15:0] e1, e2;
        logic        eu1, eu2;
    } vec_t;

    function automatic vec_t v(
        int rst_i, int wr_i, int ai_i, int di_i, int a1_i, int a2_i,
        int b1_i, int b2_i, int rs_i, int ar_i,
        int e1_i, int e2_i, int eu1_i, int eu2_i
    );
        vec_t t;
        t.rst = rst_i[0];  t.wr = wr_i[0];
        t.ai  = ai_i[2:0]; t.di = di_i[15:0];
        t.a1  = a1_i[2:0]; t.a2 = a2_i[2:0];
        t.b1  = b1_i[0];   t.b2 = b2_i[0];
        t.rs  = rs_i[0];   t.ar = ar_i[2:0];
        t.e1  = e1_i[15:0]; t.e2 = e2_i[15:0];
        t.eu1 = eu1_i[0];   t.eu2 = eu2_i[0];
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [20];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        {rst, wr, b1, b2, rs} = 5'b10000;
        {ai, a1, a2, ar} = '0; di = '0;
        {z_rst, z_wr, z_b1, z_b2, z_rs} = 5'b10000;
        {z_ai, z_a1, z_a2, z_ar} = '0; z_di = '0;
        {w_rst, w_wr, w_b1, w_b2, w_rs} = 5'b10000;
        {w_ai, w_a1, w_a2, w_ar} = '0; w_di = '0;
        tick();

        //           rst wr ai  di      a1 a2 b1 b2 rs ar  e1      e2      u1 u2
        vecs[0]  = v(0, 1, 3, 'h1234, 3, 0, 0, 0, 0, 0, 'h0000, 'h0000, 0, 0);
        vecs[1]  = v(1, 1, 3, 'h5555, 3, 0, 1, 0, 1, 3, 'h0000, 'h0000, 0, 0);
        vecs[2]  = v(0, 0, 0, 'h0000, 3, 0, 1, 0, 0, 0, 'h0000, 'h0000, 0, 0);
        vecs[3]  = v(0, 1, 5, 'hBEEF, 5, 0, 0, 0, 0, 0, 'h0000, 'h0000, 0, 0);
        vecs[4]  = v(0, 0, 0, 'h0000, 5, 5, 1, 0, 0, 0, 'hBEEF, 'h0000, 0, 0);
        vecs[5]  = v(0, 1, 2, 'h0001, 0, 0, 0, 0, 0, 0, 'hBEEF, 'h0000, 0, 0);
        vecs[6]  = v(0, 1, 2, 'h00FF, 2, 2, 1, 1, 0, 0, 'h00FF, 'h00FF, 0, 0);
        vecs[7]  = v(0, 0, 0, 'h0000, 2, 5, 0, 1, 0, 0, 'h00FF, 'hBEEF, 0, 0);
        vecs[8]  = v(0, 0, 0, 'h0000, 4, 0, 0, 0, 1, 4, 'h00FF, 'hBEEF, 0, 0);
        vecs[9]  = v(0, 0, 0, 'h0000, 4, 4, 0, 0, 0, 0, 'h00FF, 'hBEEF, 1, 1);
        vecs[10] = v(0, 1, 4, 'h0042, 4, 4, 1, 0, 0, 0, 'h0042, 'hBEEF, 0, 0);
        vecs[11] = v(0, 0, 0, 'h0000, 4, 0, 0, 0, 0, 0, 'h0042, 'hBEEF, 0, 0);
        vecs[12] = v(0, 1, 4, 'h0077, 4, 0, 0, 0, 1, 4, 'h0042, 'hBEEF, 0, 0);
        vecs[13] = v(0, 0, 0, 'h0000, 4, 0, 1, 0, 0, 0, 'h0077, 'hBEEF, 1, 0);
        vecs[14] = v(0, 1, 4, 'h0011, 4, 6, 0, 0, 1, 6, 'h0077, 'hBEEF, 0, 0);
        vecs[15] = v(0, 0, 0, 'h0000, 4, 6, 0, 1, 0, 0, 'h0077, 'h0000, 0, 1);
        vecs[16] = v(0, 0, 0, 'h0000, 6, 0, 0, 0, 1, 6, 'h0077, 'h0000, 1, 0);
        vecs[17] = v(0, 0, 0, 'h0000, 6, 7, 1, 0, 0, 0, 'h0000, 'h0000, 1, 0);
        vecs[18] = v(1, 0, 0, 'h0000, 6, 0, 1, 0, 0, 0, 'h0000, 'h0000, 1, 0);
        vecs[19] = v(0, 0, 0, 'h0000, 6, 4, 1, 1, 0, 0, 'h0000, 'h0000, 0, 0);

        for (int i = 0; i < 20; i++) begin
            rst = vecs[i].rst; wr = vecs[i].wr;
            ai = vecs[i].ai;   di = vecs[i].di;
            a1 = vecs[i].a1;   a2 = vecs[i].a2;
            b1 = vecs[i].b1;   b2 = vecs[i].b2;
            rs = vecs[i].rs;   ar = vecs[i].ar;
            #1;
            chk($sformatf("v%0d busy1", i), 32'(u1), 32'(vecs[i].eu1));
            chk($sformatf("v%0d busy2", i), 32'(u2), 32'(vecs[i].eu2));
            tick();
            chk($sformatf("v%0d reg_buff1", i), 32'(q1), 32'(vecs[i].e1));
            chk($sformatf("v%0d reg_buff2", i), 32'(q2), 32'(vecs[i].e2));
        end
        {rst, wr, b1, b2, rs} = '0;

        // zero register: writes and reservations to r0 are ignored
        z_rst = 1'b0;
        z_wr = 1'b1; z_ai = 3'd0; z_di = 16'hFFFF;
        z_rs = 1'b1; z_ar = 3'd0; z_a1 = 3'd0;
        tick();
        z_wr = 1'b0; z_rs = 1'b0; z_b1 = 1'b1;
        #1;
        chk("zero busy1", 32'(z_u1), 32'd0);
        tick();
        chk("zero reg_buff1", 32'(z_q1), 32'd0);
        z_wr = 1'b1; z_ai = 3'd0; z_di = 16'h1234;
        z_a1 = 3'd0; z_a2 = 3'd0; z_b1 = 1'b1; z_b2 = 1'b1;
        tick();
        chk("zero bypass buff1", 32'(z_q1), 32'd0);
        chk("zero bypass buff2", 32'(z_q2), 32'd0);
        z_ai = 3'd1; z_di = 16'h00AA; z_a2 = 3'd1; z_b1 = 1'b0;
        tick();
        chk("zero r1 bypass buff2", 32'(z_q2), 32'h00AA);
        z_wr = 1'b0; z_rs = 1'b1; z_ar = 3'd1; z_b2 = 1'b0;
        tick();
        z_rs = 1'b0;
        #1;
        chk("zero r1 busy2", 32'(z_u2), 32'd1);

        // wide/deep: r15 write and readback, r0..r14 untouched
        w_rst = 1'b0;
        w_wr = 1'b1; w_ai = 4'd15; w_di = 32'hDEADBEEF;
        tick();
        w_wr = 1'b0; w_a1 = 4'd15; w_b1 = 1'b1;
        tick();
        chk("wide r15", w_q1, 32'hDEADBEEF);
        for (int r = 0; r < 15; r++) begin
            w_a1 = 4'(r);
            tick();
            chk($sformatf("wide r%0d", r), w_q1, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the CPU's 8x16 register file.
- 1 write port; 2 read ports, each with a registered output buffer loaded on its own enable.
- Adds same-cycle write-to-read bypass, an optional hardwired zero register, synchronous reset of all state, and a per-register busy scoreboard.
- Sits between decode (read addresses, reservations) and writeback (write port). The control unit uses the busy flags to stall on pending results.

Parameters:
- WORD_SIZE, 16, data width in bits.
- REG_NUM, 8, number of registers; power of two, minimum 2.
- ADDR_W, 3, address width; must equal log2(REG_NUM).
- ZERO_REG, 0, when 1, register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- write  in  1  write enable for reg_file[addr_in].
- addr_in  in  ADDR_W  write address.
- data_in  in  WORD_SIZE  write data.
- addr1  in  ADDR_W  read address, port 1.
- addr2  in  ADDR_W  read address, port 2.
- write_buff1  in  1  load reg_buff1 this cycle.
- write_buff2  in  1  load reg_buff2 this cycle.
- reg_buff1  out  WORD_SIZE  registered read data, port 1.
- reg_buff2  out  WORD_SIZE  registered read data, port 2.
- reserve  in  1  mark register addr_rsv busy (pending producer).
- addr_rsv  in  ADDR_W  reservation address.
- busy1  out  1  combinational: register addr1 pending.
- busy2  out  1  combinational: register addr2 pending.

Behaviour:
- Reset: while rst=1 at posedge, all REG_NUM registers, reg_buff1, reg_buff2 and all busy bits go to 0. rst overrides write, reserve and buffer loads in the same cycle.
- Write: if write=1 at posedge, reg_file[addr_in] <= data_in. With ZERO_REG=1 and addr_in=0, the write is dropped.
- Read buffers: 1-cycle latency. If write_buffN=1 at posedge, reg_buffN <= value of reg_file[addrN], with bypass applied. Otherwise reg_buffN holds.
- Bypass: if write=1 and addr_in==addrN in the same cycle, reg_buffN loads data_in, not the old contents. This does not apply to register 0 when ZERO_REG=1, which loads 0.
- Both ports may read the same address in the same cycle; both get identical data.
- Scoreboard: one busy bit per register.
  - reserve=1 sets busy[addr_rsv] at posedge.
  - write=1 clears busy[addr_in] at posedge.
  - Same cycle, same address: the set wins, so the bit ends at 1 (a new producer is issued as the old one retires).
  - Same cycle, different addresses: both actions happen.
  - Reserving an already busy register leaves it at 1. Writing a non-busy register leaves it at 0.
- busyN = busy[addrN] AND NOT (write AND addr_in==addrN). A retiring write releases the register combinationally, consistent with bypass. Reservation does not affect busyN until the next cycle.
- With ZERO_REG=1: busy[0] is never set, and busy1/busy2 read 0 for address 0.
- Mid-operation reset: any pending reservations are discarded, and buffers read 0 on the cycle after reset.
- No X propagation: every output is defined from the first posedge with rst=1.

Decomposition:
- Shared package cpu_pkg holds:
  - WORD_SIZE and REG_NUM defaults.
  - ADDR_W derived via $clog2.
  - Register-index constant REG_ZERO=0.
- The scoreboard is a natural sub-module, regfile_scoreboard. It holds the busy vector, set/clear priority and the busy1/busy2 bypass logic.
- Storage, read buffers and data bypass stay in the top.

Test Plan:
- Reset: preload r3=0x1234, assert rst one cycle with write_buff1=1 and addr1=3 -> reg_buff1=0, r3 reads 0 afterwards, busy1=0.
- Basic write/read: write r5=0xBEEF, next cycle addr1=5 with write_buff1=1 -> reg_buff1=0xBEEF one cycle later; reg_buff2 unchanged while write_buff2=0.
- Bypass: r2=0x0001, same cycle write r2=0x00FF with addr1=addr2=2 and both buffer enables high -> reg_buff1=reg_buff2=0x00FF.
- Scoreboard: reserve r4 -> busy1=1 (addr1=4) next cycle. In the cycle write r4=0x0042 is applied, busy1=0 combinationally; busy stays 0 after. Reserve and write r4 in the same cycle -> busy1=1 afterwards.
- ZERO_REG=1: write r0=0xFFFF with reserve r0, then read r0 -> reg_buff1=0, busy1=0. Same-cycle bypass on r0 also yields 0.
- Parametrisation: WORD_SIZE=32, REG_NUM=16 -> write r15=0xDEADBEEF then read r15 -> 0xDEADBEEF; r0 through r14 are unaffected.
